// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory strobe bundle for mem_access_ctrl.
// slave: the controller; master: the CPU MEM stage plus the memory read-data return.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_slct;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_ce, mem_we, mem_addr, mem_wdata, mem_byte_slct
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_ce, mem_we, mem_addr, mem_wdata, mem_byte_slct
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequential data-memory access controller: one load/store at a time, alignment check,
// held memory strobes for WAIT_CYCLES+1 cycles, lane-aligned and extended load data.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             sext_q;
    logic             err_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rd_q;
    logic             misaligned;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;

    always_comb begin
        misaligned = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
    end

    // Controller state and latched request; every output below decodes these flops only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        sext_q  <= bus.req_sext;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= misaligned;
                        rd_q    <= '0;
                        cnt     <= '0;
                        state   <= misaligned ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        if (!we_q) begin
                            rd_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_byte = rd_q[7:0];
            2'b01:   rd_byte = rd_q[15:8];
            2'b10:   rd_byte = rd_q[23:16];
            default: rd_byte = rd_q[31:24];
        endcase
        rd_half = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
    end

    // Handshake and memory strobes; rst forces everything quiet within the reset cycle.
    always_comb begin
        bus.req_ready     = (state == IDLE) && !rst;
        bus.mem_ce        = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_byte_slct = 4'b0000;
        if ((state == ACCESS) && !rst) begin
            bus.mem_ce   = 1'b1;
            bus.mem_we   = we_q;
            bus.mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
                case (size_q)
                    2'b00: begin
                        bus.mem_byte_slct = 4'b0001 << addr_q[1:0];
                        bus.mem_wdata     = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        bus.mem_byte_slct = addr_q[1] ? 4'b1100 : 4'b0011;
                        bus.mem_wdata     = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        bus.mem_byte_slct = 4'b1111;
                        bus.mem_wdata     = wdata_q;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        if ((state == RESP) && !rst) begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            if (!we_q && !err_q) begin
                case (size_q)
                    2'b00:   bus.resp_rdata = {{24{sext_q & rd_byte[7]}}, rd_byte};
                    2'b01:   bus.resp_rdata = {{16{sext_q & rd_half[15]}}, rd_half};
                    default: bus.resp_rdata = rd_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of loads/stores against a byte-lane
// memory model, plus hand sequences for busy-hold and mid-access reset.
module tb_mem_access_ctrl;
    localparam int unsigned WC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.WAIT_CYCLES(WC), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (bus.mem_ce && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byte_slct[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end
    assign bus.mem_rdata = bus.mem_ce ? mem[bus.mem_addr[7:2]] : 32'h0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_bs;
        logic [31:0] exp_mwd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [3:0] exp_bs, input logic [31:0] exp_mwd);
        vec_t v;
        v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_bs = exp_bs; v.exp_mwd = exp_mwd;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
    endtask

    // Issue one request and observe it until its response (bounded).
    task automatic run_req(input vec_t v, output logic [31:0] rdata, output logic err,
                           output int lat, output int ce_n, output logic [3:0] bs,
                           output logic [31:0] mwd, output logic [31:0] maddr,
                           output logic mwe, output logic stable);
        rdata = 32'h0; err = 1'b0; lat = 0; ce_n = 0; bs = 4'h0;
        mwd = 32'h0; maddr = 32'h0; mwe = 1'b0; stable = 1'b1;
        @(negedge clk);
        bus.req_we = v.we; bus.req_size = v.size; bus.req_sext = v.sext;
        bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
        for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
        if (!bus.req_ready) begin
            idle_inputs();
            return;
        end
        @(negedge clk);
        idle_inputs();
        for (int c = 1; c <= 40; c++) begin
            if (bus.mem_ce) begin
                if (ce_n == 0) begin
                    bs = bus.mem_byte_slct; mwd = bus.mem_wdata;
                    maddr = bus.mem_addr; mwe = bus.mem_we;
                end else if (bs !== bus.mem_byte_slct || mwd !== bus.mem_wdata ||
                             maddr !== bus.mem_addr || mwe !== bus.mem_we) begin
                    stable = 1'b0;
                end
                ce_n++;
            end
            if (bus.resp_valid) begin
                rdata = bus.resp_rdata;
                err = bus.resp_err;
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rdata, maddr, mwd;
        logic        err, mwe, stable;
        logic [3:0]  bs;
        int          lat, ce_n, first_ready, first_ce, resp_at;
        vec_t        v;

        idle_inputs();

        //        we    size   sext  addr         wdata        rdata        err   bs       mwd
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000A5, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hA5ADBEEF, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0,        1'b0, 4'b1100, 32'h80018001));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h11, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 32'h00, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 32'h0,        1'b1, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0,        1'b1, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8001BEEF, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 4'b0001, 32'h44444444));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h00000044, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h10, 32'h00007F80, 32'h0,        1'b0, 4'b0011, 32'h7F807F80));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h00007F80, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h0000007F, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'h80017F80, 1'b0, 4'b0000, 32'h0));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst mem_ce", 32'(bus.mem_ce), 32'h0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst resp_err", 32'(bus.resp_err), 32'h0);
        chk("rst resp_rdata", bus.resp_rdata, 32'h0);
        rst = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", 32'(bus.req_ready), 32'h1);
        chk("post-rst mem_ce", 32'(bus.mem_ce), 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            run_req(v, rdata, err, lat, ce_n, bs, mwd, maddr, mwe, stable);
            chk($sformatf("v%0d rdata", i), rdata, v.exp_rdata);
            chk($sformatf("v%0d err", i), 32'(err), 32'(v.exp_err));
            chk($sformatf("v%0d latency", i), 32'(lat), v.exp_err ? 32'd1 : 32'(WC + 2));
            chk($sformatf("v%0d ce_cycles", i), 32'(ce_n), v.exp_err ? 32'd0 : 32'(WC + 1));
            if (!v.exp_err) begin
                chk($sformatf("v%0d byte_slct", i), 32'(bs), 32'(v.exp_bs));
                chk($sformatf("v%0d mem_wdata", i), mwd, v.exp_mwd);
                chk($sformatf("v%0d mem_addr", i), maddr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d mem_we", i), 32'(mwe), 32'(v.we));
                chk($sformatf("v%0d stable", i), 32'(stable), 32'h1);
            end
        end

        // req_valid held high across a busy access: second acceptance only after RESP
        @(negedge clk);
        bus.req_size = 2'b10; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
        chk("busy initial ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        first_ready = -1; first_ce = -1; resp_at = -1; ce_n = 0;
        for (int c = 1; c <= 15; c++) begin
            if (bus.mem_ce) begin
                ce_n++;
                if (first_ce < 0) first_ce = c;
            end
            if (bus.resp_valid && resp_at < 0) resp_at = c;
            if (bus.req_ready) begin
                first_ready = c;
                break;
            end
            @(negedge clk);
        end
        chk("busy first mem_ce", 32'(first_ce), 32'd1);
        chk("busy ce cycles", 32'(ce_n), 32'(WC + 1));
        chk("busy resp_valid cycle", 32'(resp_at), 32'(WC + 2));
        chk("busy next ready cycle", 32'(first_ready), 32'(WC + 3));
        @(negedge clk);
        idle_inputs();
        chk("busy second access ce", 32'(bus.mem_ce), 32'h1);
        resp_at = -1;
        for (int c = 1; c <= 20; c++) begin
            if (bus.resp_valid) begin
                resp_at = c;
                chk("busy second rdata", bus.resp_rdata, 32'h80017F80);
                break;
            end
            @(negedge clk);
        end
        chk("busy second resp seen", 32'(resp_at > 0), 32'h1);

        // Reset during the second ACCESS cycle of a store
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h20;
        bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("rst-mid ce before", 32'(bus.mem_ce), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid mem_ce", 32'(bus.mem_ce), 32'h0);
        chk("rst-mid mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst-mid byte_slct", 32'(bus.mem_byte_slct), 32'h0);
        chk("rst-mid mem_addr", bus.mem_addr, 32'h0);
        chk("rst-mid mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst-mid req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst-mid resp_valid", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        chk("rst-mid resp_valid 2", 32'(bus.resp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst-mid ready after", 32'(bus.req_ready), 32'h1);
        chk("rst-mid resp after", 32'(bus.resp_valid), 32'h0);
        chk("rst-mid ce after", 32'(bus.mem_ce), 32'h0);

        v = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80017F80, 1'b0, 4'b0000, 32'h0);
        run_req(v, rdata, err, lat, ce_n, bs, mwd, maddr, mwe, stable);
        chk("post-rst load rdata", rdata, 32'h80017F80);
        chk("post-rst load latency", 32'(lat), 32'(WC + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
